// File: rtl/macro_ram_scan_if.sv
// Bus bundle for macro_ram_scan: memory write/read ports plus the scan
// handshake. The master side drives addresses, data and scan control; the
// slave side (the memory block) returns read data and the scan stream.
interface macro_ram_scan_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              scan_start;
  logic              scan_ready;
  logic              scan_valid;
  logic [DATA_W-1:0] scan_data;
  logic              scan_busy;
  logic              scan_done;
  logic [DATA_W-1:0] scan_sum;

  modport master (
    output we, waddr, wdata, raddr, scan_start, scan_ready,
    input  rdata, scan_valid, scan_data, scan_busy, scan_done, scan_sum
  );

  modport slave (
    input  we, waddr, wdata, raddr, scan_start, scan_ready,
    output rdata, scan_valid, scan_data, scan_busy, scan_done, scan_sum
  );
endinterface

// File: rtl/macro_ram_scan.sv
// Parametrised distributed-memory macro (ROM or single-write-port RAM) with a
// registered read port and a scan engine that streams every word out under a
// valid/ready handshake while accumulating an XOR checksum.
// Memory contents come from INIT at power-up and are never touched by rst.
module macro_ram_scan #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 1,
  parameter int WRITABLE = 0,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT = '0
) (
  input logic            clk,
  input logic            rst,
  macro_ram_scan_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MEM_W = DATA_W * DEPTH;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Word k occupies bits [k*DATA_W +: DATA_W] of the flat storage vector.
  function automatic logic [DATA_W-1:0] word_at(
    input logic [MEM_W-1:0]  m,
    input logic [ADDR_W-1:0] a
  );
    return m[int'(a) * DATA_W +: DATA_W];
  endfunction

  // Storage is a flat vector so INIT maps onto it directly as power-up value.
  logic [MEM_W-1:0]  mem_q = INIT;
  logic [MEM_W-1:0]  mem_d;
  logic              wr_en;

  logic [DATA_W-1:0] rdata_q, rdata_d;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              scan_valid_q, scan_valid_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic              scan_done_q, scan_done_d;
  logic [DATA_W-1:0] scan_sum_q, scan_sum_d;
  logic              handshake;

  // Writes only exist in the RAM flavour; the ROM flavour ignores we.
  assign wr_en = (WRITABLE != 0) && bus.we;

  // Next memory image: old contents with at most one word replaced.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[int'(bus.waddr) * DATA_W +: DATA_W] = bus.wdata;
    end
  end

  // Memory update; deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read port samples the pre-write image, giving read-first behaviour.
  always_comb begin
    rdata_d = word_at(mem_q, bus.raddr);
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign handshake = scan_valid_q && bus.scan_ready;
  assign ptr_nxt   = ptr_q + 1'b1;

  // Scan FSM next state: capture word 0 on start, advance on each handshake,
  // finish with a one-cycle done pulse after the last word leaves.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    scan_valid_d = scan_valid_q;
    scan_data_d  = scan_data_q;
    scan_sum_d   = scan_sum_q;
    scan_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.scan_start) begin
          state_d      = ST_SCAN;
          ptr_d        = '0;
          scan_valid_d = 1'b1;
          scan_data_d  = word_at(mem_q, '0);
          scan_sum_d   = '0;
        end
      end
      ST_SCAN: begin
        // Stalled cycles hold the captured word even if memory is rewritten.
        if (handshake) begin
          scan_sum_d = scan_sum_q ^ scan_data_q;
          if (ptr_q == LAST_PTR) begin
            state_d      = ST_IDLE;
            scan_valid_d = 1'b0;
            scan_done_d  = 1'b1;
          end else begin
            ptr_d       = ptr_nxt;
            scan_data_d = word_at(mem_q, ptr_nxt);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan state registers; reset aborts any scan without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
      scan_done_q  <= 1'b0;
      scan_sum_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
      scan_done_q  <= scan_done_d;
      scan_sum_q   <= scan_sum_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_busy  = (state_q == ST_SCAN);
  assign bus.scan_done  = scan_done_q;
  assign bus.scan_sum   = scan_sum_q;

endmodule

// File: tb/tb_macro_ram_scan.sv
// Bench for macro_ram_scan: a 16x1 ROM instance and a 16x8 RAM instance share
// clock and reset. Read checks are table driven; scans are checked against a
// scoreboard queue filled from the bench's own memory model.
module tb_macro_ram_scan;

  localparam int DEPTH = 16;
  localparam logic [15:0]  ROM_INIT = 16'habcd;
  localparam logic [127:0] RAM_INIT = 128'hfedcba98_76543210_efcdab89_67452301;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  macro_ram_scan_if #(.ADDR_W(4), .DATA_W(1)) rom_if ();
  macro_ram_scan_if #(.ADDR_W(4), .DATA_W(8)) ram_if ();

  macro_ram_scan #(.ADDR_W(4), .DATA_W(1), .WRITABLE(0), .INIT(ROM_INIT)) u_rom (
    .clk (clk),
    .rst (rst),
    .bus (rom_if.slave)
  );

  macro_ram_scan #(.ADDR_W(4), .DATA_W(8), .WRITABLE(1), .INIT(RAM_INIT)) u_ram (
    .clk (clk),
    .rst (rst),
    .bus (ram_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb[$];

  // Expected memory contents, written out independently of the INIT vectors.
  bit         rom_exp[16]   = '{1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1};
  logic [7:0] ram_model[16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef,
                                8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hba, 8'hdc, 8'hfe};

  typedef struct {
    logic [3:0] raddr;
    logic       we;
    logic [3:0] waddr;
    logic       wdata;
    logic       exp;
  } rom_vec_t;

  rom_vec_t rom_tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit sel, input logic r);
    if (sel) ram_if.scan_ready = r;
    else     rom_if.scan_ready = r;
  endtask

  task automatic set_start(input bit sel, input logic s);
    if (sel) ram_if.scan_start = s;
    else     rom_if.scan_start = s;
  endtask

  task automatic sample(input bit sel, output logic v, output logic [7:0] d,
                        output logic busy, output logic done, output logic [7:0] sum);
    if (sel) begin
      v = ram_if.scan_valid; d = ram_if.scan_data; busy = ram_if.scan_busy;
      done = ram_if.scan_done; sum = ram_if.scan_sum;
    end else begin
      v = rom_if.scan_valid; d = 8'(rom_if.scan_data); busy = rom_if.scan_busy;
      done = rom_if.scan_done; sum = 8'(rom_if.scan_sum);
    end
  endtask

  // One scan on the selected instance. toggle: ready alternates 0,1.
  // restart_at: pulse scan_start while that word is presented (-1: never).
  // rst_after: assert rst once that many words have handshaken (-1: never).
  task automatic scan_run(input bit sel, input bit toggle, input int restart_at,
                          input int rst_after);
    logic v, busy, done, rdy;
    logic [7:0] d, sum, prev_d, exp_sum, run_sum, w, exp_w;
    bit prev_stall, rst_next, restarted;
    int hs, done_cnt, done_cyc, bad_overlap, bad_busy, extra, after_rst;

    sb.delete();
    exp_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w = sel ? ram_model[k] : 8'(rom_exp[k]);
      sb.push_back(w);
      exp_sum ^= w;
    end
    run_sum = '0; prev_d = '0; prev_stall = 0; rst_next = 0; restarted = 0;
    hs = 0; done_cnt = 0; done_cyc = -1; bad_overlap = 0; bad_busy = 0;

    set_ready(sel, 1'b0);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);

    for (int cyc = 0; cyc < 200; cyc++) begin
      sample(sel, v, d, busy, done, sum);

      if (rst_next) begin
        chk("sum_mid_scan", sum, run_sum);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample(sel, v, d, busy, done, sum);
        chk("rst_valid", v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_done", done, 0);
        after_rst = 0;
        for (int j = 0; j < 4; j++) begin
          tick();
          sample(sel, v, d, busy, done, sum);
          if (done || v || busy) after_rst++;
        end
        chk("quiet_after_rst", after_rst, 0);
        set_ready(sel, 1'b0);
        return;
      end

      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (v && done) bad_overlap++;
      if (busy !== v) bad_busy++;

      if (v && prev_stall) chk("stall_hold", d, prev_d);

      if (restart_at >= 0 && !restarted && v && hs == restart_at) begin
        set_start(sel, 1'b1);
        restarted = 1;
      end else begin
        set_start(sel, 1'b0);
      end

      rdy = toggle ? 1'(cyc % 2) : 1'b1;
      set_ready(sel, rdy);

      if (v && rdy) begin
        if (sb.size() == 0) begin
          extra = hs + 1;
          chk("scan_extra_word", extra, DEPTH);
        end else begin
          exp_w = sb.pop_front();
          chk("scan_word", d, exp_w);
        end
        run_sum ^= d;
        hs++;
        prev_stall = 0;
        if (rst_after >= 0 && hs == rst_after) rst_next = 1;
      end else begin
        prev_stall = v;
      end
      prev_d = d;

      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      tick();
    end

    set_start(sel, 1'b0);
    set_ready(sel, 1'b0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, toggle ? 2 * DEPTH : DEPTH);
    chk("handshakes", hs, DEPTH);
    chk("sb_empty", sb.size(), 0);
    chk("scan_sum", sum, exp_sum);
    chk("valid_done_overlap", bad_overlap, 0);
    chk("busy_vs_valid", bad_busy, 0);
    chk("idle_after_done", v, 0);
  endtask

  initial begin
    rst = 1'b1;
    rom_if.we = 0; rom_if.waddr = '0; rom_if.wdata = '0; rom_if.raddr = '0;
    rom_if.scan_start = 0; rom_if.scan_ready = 0;
    ram_if.we = 0; ram_if.waddr = '0; ram_if.wdata = '0; ram_if.raddr = '0;
    ram_if.scan_start = 0; ram_if.scan_ready = 0;

    // Reset state
    tick();
    tick();
    chk("rom_rdata_rst", rom_if.rdata, 0);
    chk("rom_valid_rst", rom_if.scan_valid, 0);
    chk("rom_data_rst", rom_if.scan_data, 0);
    chk("rom_busy_rst", rom_if.scan_busy, 0);
    chk("rom_done_rst", rom_if.scan_done, 0);
    chk("rom_sum_rst", rom_if.scan_sum, 0);
    chk("ram_rdata_rst", ram_if.rdata, 0);
    chk("ram_valid_rst", ram_if.scan_valid, 0);
    chk("ram_sum_rst", ram_if.scan_sum, 0);
    rst = 1'b0;

    // ROM readback sweep, then attempted writes that must be ignored
    for (int i = 0; i < 16; i++) begin
      rom_tbl[i] = '{raddr: 4'(i), we: 1'b0, waddr: 4'd0, wdata: 1'b0, exp: rom_exp[i]};
    end
    rom_tbl[16] = '{raddr: 4'd0, we: 1'b1, waddr: 4'd0, wdata: 1'b0, exp: 1'b1};
    rom_tbl[17] = '{raddr: 4'd0, we: 1'b1, waddr: 4'd2, wdata: 1'b0, exp: 1'b1};
    rom_tbl[18] = '{raddr: 4'd2, we: 1'b0, waddr: 4'd0, wdata: 1'b0, exp: 1'b1};
    rom_tbl[19] = '{raddr: 4'd0, we: 1'b0, waddr: 4'd0, wdata: 1'b0, exp: 1'b1};
    for (int i = 0; i < 20; i++) begin
      rom_if.raddr = rom_tbl[i].raddr;
      rom_if.we    = rom_tbl[i].we;
      rom_if.waddr = rom_tbl[i].waddr;
      rom_if.wdata = rom_tbl[i].wdata;
      tick();
      chk("rom_rdata", rom_if.rdata, rom_tbl[i].exp);
    end
    rom_if.we = 0;

    // RAM write with read-first collision, then persistence across reset
    ram_if.we = 1; ram_if.waddr = 4'd3; ram_if.wdata = 8'h5a; ram_if.raddr = 4'd3;
    tick();
    chk("ram_read_first", ram_if.rdata, 8'h67);
    ram_model[3] = 8'h5a;
    ram_if.we = 0;
    tick();
    chk("ram_read_new", ram_if.rdata, 8'h5a);
    rst = 1'b1;
    tick();
    chk("ram_rdata_in_rst", ram_if.rdata, 0);
    rst = 1'b0;
    tick();
    chk("ram_survives_rst", ram_if.rdata, 8'h5a);
    ram_if.raddr = 4'd5;
    tick();
    chk("ram_other_word", ram_if.rdata, 8'hab);

    // Full ROM scan, no backpressure
    scan_run(1'b0, 1'b0, -1, -1);
    // RAM scan with ready toggling 0,1
    scan_run(1'b1, 1'b1, -1, -1);
    // Reset after word 5 handshakes, then a fresh scan from word 0
    scan_run(1'b1, 1'b0, -1, 6);
    scan_run(1'b1, 1'b0, -1, -1);
    // Start pulse while busy at word 7 is ignored
    scan_run(1'b0, 1'b0, 7, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/macro_ram_scan.md
# macro_ram_scan

Parametrised distributed-memory macro block for architecture feature tests. It generalises the fixed 16x1 ROM macro to configurable depth, width and writability. It adds a registered read port and a sequential scan engine that streams every word out under valid/ready handshake and accumulates an XOR checksum. It sits between the input and output buffer cells of a feature-test top and exercises LUT-RAM/ROM macro expansion plus surrounding sequential logic in place and route.

## Interface

Parameters:
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W; legal range 4..6.
- DATA_W, 1, word width; legal range 1..8.
- WRITABLE, 0, 0 = ROM behaviour (writes ignored), 1 = single-port-write RAM.
- INIT, all zero, DATA_W*DEPTH bits; word k = INIT[k*DATA_W +: DATA_W].

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable; honoured only when WRITABLE=1.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- scan_start  in  1  start a scan; sampled only in IDLE.
- scan_ready  in  1  sink ready for scan_data.
- scan_valid  out  1  scan_data holds a valid word.
- scan_data  out  DATA_W  current scanned word.
- scan_busy  out  1  high while state is SCAN.
- scan_done  out  1  one-cycle pulse after the last word handshakes.
- scan_sum  out  DATA_W  XOR of all words handshaken in the last or current scan.

## Operation

- Memory powers up with INIT contents. Memory is not affected by rst; written contents survive reset.
- Write: WRITABLE=1 and we=1 -> mem[waddr] <= wdata at the edge. WRITABLE=0 -> we, waddr and wdata have no effect.
- Read: rdata <= mem[raddr] every cycle. Read-first: when raddr==waddr with a write in the same cycle, rdata gets the old word.
- Scan FSM has two states, IDLE and SCAN, plus an internal pointer ptr of ADDR_W bits.
  - IDLE with scan_start=1 -> SCAN. On this transition: ptr<=0, scan_data<=mem[0] (read-first), scan_valid<=1, scan_sum<=0.
  - SCAN, handshake (scan_valid & scan_ready), ptr!=DEPTH-1: scan_sum ^= scan_data, ptr<=ptr+1, scan_data<=mem[ptr+1] (read-first).
  - SCAN, handshake, ptr==DEPTH-1: scan_sum ^= scan_data, scan_valid<=0, scan_done<=1 for one cycle, state<=IDLE.
  - SCAN without handshake: scan_data, ptr and scan_sum hold. A write to mem[ptr] while stalled does not alter the captured scan_data.
- scan_start while in SCAN is ignored. scan_start in the same cycle as the final handshake is ignored, because the FSM is still in SCAN.
- scan_busy = (state==SCAN).
- scan_sum is stable from scan_done until the next scan start.
- Writes during a scan are allowed. Words at addresses not yet captured reflect the new contents.

## Timing

- Reset values: rdata=0, scan_valid=0, scan_data=0, scan_busy=0, scan_done=0, scan_sum=0; state=IDLE, ptr=0.
- rst asserted mid-scan aborts the scan at that edge: the outputs above are forced, no scan_done pulse is produced, and memory is unchanged.
- Read latency is 1 cycle from raddr to rdata.
- Scan timing:
  - scan_start sampled at edge E0 -> scan_valid=1 with word 0 after E0.
  - With scan_ready held high, word k is presented after edge E0+k.
  - The last handshake occurs at E0+DEPTH; scan_done is high for the cycle following that edge.
  - The minimum scan therefore takes DEPTH+1 cycles from start to scan_done.
- Each cycle with scan_ready=0 while scan_valid=1 adds exactly one cycle.
- scan_done and scan_valid are never high together.

## Test plan

- ROM readback: ADDR_W=4, DATA_W=1, WRITABLE=0, INIT=16'habcd. Sweep raddr 0..15 -> rdata sequence 1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1, one cycle late. Also we=1 with waddr=0, wdata=0 -> address 0 still reads 1.
- RAM write and read-first: WRITABLE=1, DATA_W=8. Write 8'h5a to address 3 with raddr=3 in the same cycle -> rdata = old INIT word; next cycle rdata=8'h5a. After an rst pulse, address 3 still reads 8'h5a.
- Full scan, no backpressure: ROM config above with scan_ready=1. Pulse scan_start -> 16 valid words matching the sweep above, scan_done one cycle after the 16th word (17 cycles after start), scan_sum=0.
- Backpressure: DATA_W=8. Toggle scan_ready 1,0 repeatedly -> each word held for 2 cycles, data stable while stalled, word order unchanged, scan_sum = XOR of all INIT words.
- Reset mid-scan: assert rst after word 5 handshakes -> next cycle scan_valid=0, scan_busy=0, scan_sum=0, no scan_done. A fresh scan_start then restarts from word 0.
- Start while busy: pulse scan_start at word 7 -> ignored. Exactly DEPTH words and exactly one scan_done are produced.
